// File: rtl/select_carry_pkg.sv
// Shared constants and parameter checks for the pipelined carry-select adder family.
package select_carry_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  localparam int unsigned DEF_WIDTH  = 64;
  localparam int unsigned DEF_STAGES = 4;
  localparam int unsigned DEF_BLK    = 8;

  // Legal when every stage splits evenly into whole BLK-bit segments.
  function automatic bit params_ok(input int unsigned w, input int unsigned s,
                                   input int unsigned b);
    return (s != 0) && (b != 0) && ((w % (s * b)) == 0);
  endfunction

endpackage

// File: rtl/select_carry_segment.sv
// One carry-select segment: sums for carry-in 0 and 1 formed in parallel, carry-in picks one.
module select_carry_segment #(
  parameter int unsigned BLK = 8
) (
  input  logic [BLK-1:0] a,
  input  logic [BLK-1:0] b,
  input  logic           cin,
  output logic [BLK-1:0] sum,
  output logic           cout
);

  logic [BLK:0] w_r0;
  logic [BLK:0] w_r1;

  assign w_r0        = {1'b0, a} + {1'b0, b};
  assign w_r1        = {1'b0, a} + {1'b0, b} + {{BLK{1'b0}}, 1'b1};
  assign {cout, sum} = cin ? w_r1 : w_r0;

endmodule

// File: rtl/pipelined_select_carry_adder.sv
// Streaming carry-select adder/subtractor: one WIDTH/STAGES slice per stage, carry registered between slices.
module pipelined_select_carry_adder
  import select_carry_pkg::*;
#(
  parameter int unsigned WIDTH  = DEF_WIDTH,
  parameter int unsigned STAGES = DEF_STAGES,
  parameter int unsigned BLK    = DEF_BLK
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf
);

  localparam int unsigned SW   = WIDTH / STAGES;
  localparam int unsigned NSEG = SW / BLK;

  if (!params_ok(WIDTH, STAGES, BLK)) begin : g_bad_params
    $error("pipelined_select_carry_adder: WIDTH must be a multiple of STAGES*BLK");
  end

  logic              w_en;
  logic              w_acc;
  logic [WIDTH-1:0]  w_b_in;
  logic              w_c_in;
  logic [STAGES-1:0] r_vld;
  logic              r_ovf;
  logic              w_c_msb_in;
  logic              w_ovf_nxt;

  // The whole pipe advances together; a stalled output freezes every stage.
  assign w_en     = !r_vld[STAGES-1] || out_ready;
  assign in_ready = w_en;
  assign w_acc    = in_valid && w_en;
  assign w_b_in   = (in_sub == OP_ADD) ? in_b : ~in_b;
  assign w_c_in   = (in_sub == OP_SUB) ? 1'b1 : in_cin;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_vld <= '0;
    end else if (w_en) begin
      r_vld[0] <= w_acc;
      for (int unsigned i = 1; i < STAGES; i++) begin
        r_vld[i] <= r_vld[i-1];
      end
    end
  end

  // Operand skew: g_skew[s] holds the operand bits not yet consumed after stage s.
  for (genvar s = 0; s < STAGES - 1; s++) begin : g_skew
    logic [WIDTH-(s+1)*SW-1:0] r_a;
    logic [WIDTH-(s+1)*SW-1:0] r_b;
    logic [WIDTH-(s+1)*SW-1:0] w_a_nxt;
    logic [WIDTH-(s+1)*SW-1:0] w_b_nxt;

    if (s == 0) begin : g_head
      assign w_a_nxt = in_a[WIDTH-1:SW];
      assign w_b_nxt = w_b_in[WIDTH-1:SW];
    end else begin : g_tail
      assign w_a_nxt = g_skew[s-1].r_a[WIDTH-s*SW-1:SW];
      assign w_b_nxt = g_skew[s-1].r_b[WIDTH-s*SW-1:SW];
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_a <= '0;
        r_b <= '0;
      end else if (w_en) begin
        r_a <= w_a_nxt;
        r_b <= w_b_nxt;
      end
    end
  end

  // Stage s resolves slice s; r_sum accumulates the de-skewed low slices.
  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    logic [SW-1:0]         w_a;
    logic [SW-1:0]         w_b;
    logic [SW-1:0]         w_sum;
    logic [NSEG:0]         w_c;
    logic [(s+1)*SW-1:0]   w_sum_nxt;
    logic [(s+1)*SW-1:0]   r_sum;
    logic                  r_c;

    if (s == 0) begin : g_first
      assign w_a       = in_a[SW-1:0];
      assign w_b       = w_b_in[SW-1:0];
      assign w_c[0]    = w_c_in;
      assign w_sum_nxt = w_sum;
    end else begin : g_next
      assign w_a       = g_skew[s-1].r_a[SW-1:0];
      assign w_b       = g_skew[s-1].r_b[SW-1:0];
      assign w_c[0]    = g_stage[s-1].r_c;
      assign w_sum_nxt = {w_sum, g_stage[s-1].r_sum};
    end

    for (genvar g = 0; g < NSEG; g++) begin : g_seg
      select_carry_segment #(.BLK(BLK)) u_seg (
        .a   (w_a[g*BLK +: BLK]),
        .b   (w_b[g*BLK +: BLK]),
        .cin (w_c[g]),
        .sum (w_sum[g*BLK +: BLK]),
        .cout(w_c[g+1])
      );
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_sum <= '0;
        r_c   <= 1'b0;
      end else if (w_en) begin
        r_sum <= w_sum_nxt;
        r_c   <= w_c[NSEG];
      end
    end
  end

  // Carry into the MSB recovered from the MSB's own sum bit: a ^ b ^ s.
  assign w_c_msb_in = g_stage[STAGES-1].w_a[SW-1] ^ g_stage[STAGES-1].w_b[SW-1]
                    ^ g_stage[STAGES-1].w_sum[SW-1];
  assign w_ovf_nxt  = w_c_msb_in ^ g_stage[STAGES-1].w_c[NSEG];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
    end else if (w_en) begin
      r_ovf <= w_ovf_nxt;
    end
  end

  assign out_valid = r_vld[STAGES-1];
  assign out_sum   = g_stage[STAGES-1].r_sum;
  assign out_cout  = g_stage[STAGES-1].r_c;
  assign out_ovf   = r_ovf;

endmodule

// File: doc/pipelined_select_carry_adder.md
Name: pipelined_select_carry_adder

Overview:
- Parametrised, pipelined carry-select adder/subtractor. It is the streaming successor to the combinational 64-bit select-carry adder.
- Operands enter through a valid/ready handshake. Results leave STAGES cycles later with carry-out and signed overflow.
- The datapath is split into STAGES slices of WIDTH/STAGES bits. The carry is registered between slices, and operands and partial sums are skewed and de-skewed by delay registers.
- The block sits between an operand source (ALU issue / test driver) and a result consumer, and supports back-pressure.

Parameters:
- WIDTH, 64, operand/sum width. Must be divisible by STAGES*BLK.
- STAGES, 4, pipeline depth = latency in cycles. Each stage resolves WIDTH/STAGES bits.
- BLK, 8, carry-select segment width inside a stage.

Ports:
- clk  input  1  single clock, rising edge
- rst_n  input  1  reset, synchronous, active-low
- in_valid  input  1  operand beat valid
- in_ready  output  1  block can accept a beat this cycle
- in_a  input  WIDTH  operand A
- in_b  input  WIDTH  operand B
- in_cin  input  1  carry-in (ADD mode only)
- in_sub  input  1  0 = ADD (a+b+cin), 1 = SUB (a+~b+1; cin ignored)
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- out_sum  output  WIDTH  result
- out_cout  output  1  carry-out (SUB: 1 = no borrow)
- out_ovf  output  1  signed two's-complement overflow

Behaviour:
- Reset: sampled on posedge clk while rst_n==0.
  - All stage valid bits clear; all data/carry registers clear.
  - out_valid=0, out_sum=0, out_cout=0, out_ovf=0, in_ready=1 from the first edge with rst_n low.
- Reset mid-operation: in-flight beats are discarded. No result from a pre-reset beat ever appears.
- Global advance enable: en = !out_valid || out_ready. in_ready = en.
  - Handshake: a beat is accepted when in_valid && in_ready.
  - When en=1, every stage register shifts one slot. Stage 0 loads the accepted beat, or a bubble (valid=0) if none.
  - When en=0, all stage registers, including outputs, hold. Bubbles are not collapsed.
- Latency: a beat accepted at edge k presents out_valid=1 after edge k+STAGES-1 (STAGES cycles incl. input registration), provided no stall.
- Throughput: one beat per cycle while out_ready=1.
- Stage s, s=0..STAGES-1: computes bits [s*W/S +: W/S] from the skewed a, b' (b' = in_sub ? ~b : b) and the registered carry from stage s-1.
  - Stage 0 carry = in_sub ? 1 : in_cin.
- Within a stage: W/S/BLK segments. Each segment computes a ripple sum for carry 0 and for carry 1 in parallel; the incoming carry selects via mux. Segment 0 of a stage may ripple directly.
- out_cout = carry out of MSB. out_ovf = carry into MSB XOR carry out of MSB.
- Arithmetic is modulo 2^WIDTH; wrap-around is not an error.
- A simultaneous accept and output transfer in the same cycle is legal and required for full throughput.
- in_sub, in_cin and the operands are captured only on accept. Changes while in_ready=0 are ignored.
- Elaboration: an illegal parameter combination (WIDTH % (STAGES*BLK) != 0) must trigger an elaboration-time error (generate-block $error or equivalent).

Decomposition:
- Shared package/include select_carry_pkg: opcode constants OP_ADD=1'b0, OP_SUB=1'b1; default WIDTH/STAGES/BLK localparams; a parameter-check macro.
- Sub-module select_carry_segment (param BLK): inputs a, b, cin; outputs sum, cout. Dual ripple plus select mux, purely combinational.
- Top: generate loops for stages and segments; skew/de-skew shift registers; handshake control.

Test Plan (WIDTH=64, STAGES=4, BLK=8):
- Reset: hold rst_n=0 for 2 cycles with in_valid=1 -> out_valid=0, out_sum=0, in_ready=1, no results after release until new accepts.
- ADD wrap: a=64'hFFFF_FFFF_FFFF_FFFF, b=1, cin=0, out_ready=1 -> 4 cycles later sum=0, cout=1, ovf=0.
- ADD signed overflow: a=64'h7FFF_FFFF_FFFF_FFFF, b=1, cin=0 -> sum=64'h8000_0000_0000_0000, cout=0, ovf=1. Also a=0, b=0, cin=1 -> sum=1.
- SUB borrow: a=5, b=7, in_sub=1, cin=1 (ignored) -> sum=64'hFFFF_FFFF_FFFF_FFFE, cout=0, ovf=0. Then a=7, b=5 -> sum=2, cout=1.
- Back-pressure: stream 8 incrementing-operand beats; drop out_ready for 3 cycles mid-stream -> in_ready=0 exactly while out_valid && !out_ready. All 8 results emerge in order, none lost or duplicated, each matching a reference a+b+cin model.
- Reset in flight: 3 beats accepted, then rst_n=0 for 1 cycle -> out_valid=0 next cycle, and none of the 3 results ever appear.
